// File: rtl/spark_channel_demux.sv
// rtl/spark_channel_demux.sv - round-robin spark pulse demultiplexer with cam sync and dwell limit
//
// Splits one combined spark stream into CHANNEL_COUNT coil outputs in round-robin order.
// Optional feature macro: SPARK_DEMUX_SYNC_CHECK_EN (builds the sync_err alignment check).
//
// Ports:
//   clk          - sole clock
//   rst_n        - asynchronous active-low reset
//   enable       - 0 forces unsynced, outputs low, fault cleared
//   pulse_in     - combined spark stream (high = dwell, falling edge fires)
//   sync         - cam sync; rising edge aligns the next pulse to channel 0
//   max_dwell    - maximum output-high cycles, 0 = unlimited
//   outputs      - per-channel coil drive, registered, at most one bit high
//   channel_idx  - channel used by the current or next pulse
//   synced       - a sync edge has been accepted
//   dwell_fault  - sticky, a pulse was truncated by the dwell limit
//   sync_err     - one-cycle pulse on misaligned resync (0 unless macro defined)

module spark_channel_demux #(
    parameter int  CHANNEL_COUNT = 4,
    parameter int  DWELL_WIDTH   = 16,
    localparam int IDX_W         = $clog2(CHANNEL_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     pulse_in,
    input  logic                     sync,
    input  logic [DWELL_WIDTH-1:0]   max_dwell,
    output logic [CHANNEL_COUNT-1:0] outputs,
    output logic [IDX_W-1:0]         channel_idx,
    output logic                     synced,
    output logic                     dwell_fault,
    output logic                     sync_err
);

    typedef enum logic [1:0] {
        ST_UNSYNCED,
        ST_IDLE,
        ST_ACTIVE,
        ST_LOCKOUT
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic                     pulse_s;
    logic                     pulse_d;
    logic                     sync_s;
    logic                     sync_d;
    logic                     sync_pending;
    logic [DWELL_WIDTH-1:0]   dwell_cnt;

    logic [CHANNEL_COUNT-1:0] outputs_n;
    logic [IDX_W-1:0]         idx_n;
    logic                     synced_n;
    logic                     fault_n;
    logic                     pending_n;
    logic [DWELL_WIDTH-1:0]   cnt_n;

    logic                     pulse_rise;
    logic                     pulse_fall;
    logic                     sync_rise;
    logic                     realign;
    logic [IDX_W-1:0]         idx_adv;
    logic [IDX_W-1:0]         start_idx;

    assign pulse_rise = pulse_s & ~pulse_d;
    assign pulse_fall = ~pulse_s & pulse_d;
    assign sync_rise  = sync_s & ~sync_d;
    // A sync seen during a pulse (pending) or on the completing edge itself realigns to 0.
    assign realign    = sync_pending | sync_rise;
    assign idx_adv    = (channel_idx == IDX_W'(CHANNEL_COUNT - 1)) ? '0 : channel_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_UNSYNCED;
            pulse_s      <= 1'b0;
            pulse_d      <= 1'b0;
            sync_s       <= 1'b0;
            sync_d       <= 1'b0;
            outputs      <= '0;
            channel_idx  <= '0;
            synced       <= 1'b0;
            dwell_fault  <= 1'b0;
            sync_pending <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            state        <= state_n;
            pulse_s      <= pulse_in;
            pulse_d      <= pulse_s;
            sync_s       <= sync;
            sync_d       <= sync_s;
            outputs      <= outputs_n;
            channel_idx  <= idx_n;
            synced       <= synced_n;
            dwell_fault  <= fault_n;
            sync_pending <= pending_n;
            dwell_cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        outputs_n = outputs;
        idx_n     = channel_idx;
        synced_n  = synced;
        fault_n   = dwell_fault;
        pending_n = sync_pending;
        cnt_n     = dwell_cnt;
        start_idx = channel_idx;

        if (!enable) begin
            state_n   = ST_UNSYNCED;
            outputs_n = '0;
            synced_n  = 1'b0;
            fault_n   = 1'b0;
            pending_n = 1'b0;
        end else begin
            case (state)
                ST_UNSYNCED: begin
                    outputs_n = '0;
                    if (sync_rise) begin
                        idx_n    = '0;
                        synced_n = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    // Sync wins over a simultaneous pulse start, so that pulse lands on channel 0.
                    if (sync_rise) begin
                        idx_n     = '0;
                        start_idx = '0;
                    end
                    if (pulse_rise) begin
                        outputs_n = CHANNEL_COUNT'(1) << start_idx;
                        cnt_n     = DWELL_WIDTH'(1);
                        state_n   = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (dwell_cnt != '1) begin
                        cnt_n = dwell_cnt + 1'b1;
                    end
                    if (sync_rise) begin
                        pending_n = 1'b1;
                    end
                    // A fall on the very cycle the limit is reached is a normal completion.
                    if (pulse_fall) begin
                        outputs_n = '0;
                        idx_n     = realign ? '0 : idx_adv;
                        pending_n = 1'b0;
                        state_n   = ST_IDLE;
                    end else if (pulse_s && (max_dwell != '0) && (dwell_cnt == max_dwell)) begin
                        outputs_n = '0;
                        fault_n   = 1'b1;
                        state_n   = ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: begin
                    outputs_n = '0;
                    if (sync_rise) begin
                        pending_n = 1'b1;
                    end
                    if (pulse_fall) begin
                        idx_n     = realign ? '0 : idx_adv;
                        pending_n = 1'b0;
                        state_n   = ST_IDLE;
                    end
                end
                default: begin
                    outputs_n = '0;
                    state_n   = ST_UNSYNCED;
                end
            endcase
        end
    end

`ifdef SPARK_DEMUX_SYNC_CHECK_EN
    logic sync_err_q;
    logic sync_err_n;

    // Flags a realignment that actually moves the rotation: the index it replaces is not 0.
    always_comb begin
        sync_err_n = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE:               sync_err_n = sync_rise && (channel_idx != '0);
                ST_ACTIVE, ST_LOCKOUT: sync_err_n = pulse_fall && realign && (idx_adv != '0);
                default:               sync_err_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_n;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_spark_channel_demux.sv
// tb/tb_spark_channel_demux.sv - directed bench with per-cycle expected-waveform model for spark_channel_demux
module tb_spark_channel_demux;

    localparam int N     = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pulse_in;
    logic        sync;
    logic [15:0] max_dwell;
    logic [3:0]  outputs;
    logic [1:0]  channel_idx;
    logic        synced;
    logic        dwell_fault;
    logic        sync_err;

    spark_channel_demux #(.CHANNEL_COUNT(N), .DWELL_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .sync        (sync),
        .max_dwell   (max_dwell),
        .outputs     (outputs),
        .channel_idx (channel_idx),
        .synced      (synced),
        .dwell_fault (dwell_fault),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected waveforms indexed by posedge count; each entry is what the outputs hold after that edge.
    logic [3:0] exp_out [DEPTH];
    logic       exp_syn [DEPTH];
    logic       exp_flt [DEPTH];
    logic       exp_err [DEPTH];
    logic [1:0] exp_idx [DEPTH];

    int n_vec = 0;
    int n_bad = 0;
    int hi_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;
    bit m_synced = 1'b0;
    int next_ch = 0;
    int m_max = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void fill_syn(input int from, input logic v);
        for (int c = from; c < DEPTH; c++) exp_syn[c] = v;
    endfunction

    function automatic void fill_flt(input int from, input logic v);
        for (int c = from; c < DEPTH; c++) exp_flt[c] = v;
    endfunction

    function automatic void fill_idx(input int from, input int v);
        for (int c = from; c < DEPTH; c++) exp_idx[c] = 2'(v);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", outputs, exp_out[cyc]);
            check("synced", synced, exp_syn[cyc]);
            check("dwell_fault", dwell_fault, exp_flt[cyc]);
            check("channel_idx", channel_idx, exp_idx[cyc]);
            check("sync_err", sync_err, exp_err[cyc]);
            check("onehot", int'($countones(outputs) <= 1), 1);
        end
        if (outputs != 4'd0) hi_cnt++;
        if (sync_err) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_sync(input int gap);
        int p;
        p = cyc;
`ifdef SPARK_DEMUX_SYNC_CHECK_EN
        if (m_synced && next_ch != 0) exp_err[p + 2] = 1'b1;
`endif
        m_synced = 1'b1;
        next_ch  = 0;
        fill_syn(p + 2, 1'b1);
        fill_idx(p + 2, 0);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        tick(gap);
    endtask

    // One input pulse of width w; sync_at >= 0 raises sync for one cycle that many cycles after the rise.
    task automatic pulse(input int w, input int gap, input int sync_at);
        int  p, ch, len;
        bit  trunc;
        p = cyc;
        if (m_synced) begin
            if (sync_at == 0) begin
`ifdef SPARK_DEMUX_SYNC_CHECK_EN
                if (next_ch != 0) exp_err[p + 2] = 1'b1;
`endif
                next_ch = 0;
                fill_idx(p + 2, 0);
            end
            ch    = next_ch;
            trunc = (m_max != 0) && (w > m_max);
            len   = trunc ? m_max : w;
            for (int i = 0; i < len; i++) exp_out[p + 2 + i] = 4'(1 << ch);
            if (trunc) fill_flt(p + 2 + m_max, 1'b1);
            if (sync_at > 0) begin
`ifdef SPARK_DEMUX_SYNC_CHECK_EN
                if ((ch + 1) % N != 0) exp_err[p + w + 2] = 1'b1;
`endif
                next_ch = 0;
            end else begin
                next_ch = (ch + 1) % N;
            end
            fill_idx(p + w + 2, next_ch);
        end
        pulse_in = 1'b1;
        for (int i = 0; i < w; i++) begin
            sync = (i == sync_at);
            tick(1);
        end
        pulse_in = 1'b0;
        sync     = 1'b0;
        tick(gap);
    endtask

    task automatic disable_for(input int n);
        int p;
        p = cyc;
        m_synced = 1'b0;
        fill_syn(p + 1, 1'b0);
        fill_flt(p + 1, 1'b0);
        enable = 1'b0;
        tick(n);
        enable = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < DEPTH; c++) begin
            exp_out[c] = 4'd0;
            exp_syn[c] = 1'b0;
            exp_flt[c] = 1'b0;
            exp_err[c] = 1'b0;
            exp_idx[c] = 2'd0;
        end
        rst_n     = 1'b0;
        enable    = 1'b1;
        pulse_in  = 1'b0;
        sync      = 1'b0;
        max_dwell = 16'd0;
        tick(3);
        check("rst_outputs", outputs, 0);
        check("rst_idx", channel_idx, 0);
        check("rst_synced", synced, 0);
        check("rst_fault", dwell_fault, 0);
        check("rst_err", sync_err, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // pulses before any sync are ignored
        hi_cnt = 0;
        pulse(6, 4, -1);
        pulse(6, 4, -1);
        check("presync_hi", hi_cnt, 0);
        check("presync_synced", synced, 0);
        do_sync(4);
        check("sync_synced", synced, 1);

        // five 10-cycle pulses rotate 0,1,2,3,0
        hi_cnt = 0;
        repeat (5) pulse(10, 4, -1);
        check("rr_hi", hi_cnt, 50);
        check("rr_idx", channel_idx, 1);

        // dwell limit truncates, fault is sticky until enable drops
        max_dwell = 16'd5;
        m_max     = 5;
        hi_cnt    = 0;
        pulse(20, 4, -1);
        check("lim_hi", hi_cnt, 5);
        check("lim_fault", dwell_fault, 1);
        max_dwell = 16'd0;
        m_max     = 0;
        pulse(8, 4, -1);
        check("lim_fault_sticky", dwell_fault, 1);
        check("lim_next_idx", channel_idx, 3);
        disable_for(3);
        check("dis_fault", dwell_fault, 0);
        check("dis_synced", synced, 0);
        do_sync(4);

        // width equal to the limit is not a fault; one cycle more is
        max_dwell = 16'd6;
        m_max     = 6;
        hi_cnt    = 0;
        pulse(6, 4, -1);
        check("eq_hi", hi_cnt, 6);
        check("eq_fault", dwell_fault, 0);
        pulse(7, 4, -1);
        check("over_hi", hi_cnt, 12);
        check("over_fault", dwell_fault, 1);
        max_dwell = 16'd0;
        m_max     = 0;

        // sync mid-pulse on channel 2: full width, next pulse on channel 0
        check("mid_idx_before", channel_idx, 2);
        hi_cnt = 0;
        pulse(10, 4, 3);
        check("mid_hi", hi_cnt, 10);
        check("mid_idx_after", channel_idx, 0);
        pulse(5, 4, -1);

        // sync together with pulse start while idx=3 sends the pulse to channel 0
        pulse(5, 4, -1);
        pulse(5, 4, -1);
        check("same_idx_before", channel_idx, 3);
        pulse(6, 4, 0);
        check("same_idx_after", channel_idx, 1);

`ifdef SPARK_DEMUX_SYNC_CHECK_EN
        check("err_count", err_cnt, 2);
`else
        check("err_count", err_cnt, 0);
`endif

        // reset mid-pulse drops outputs without waiting for a clock
        chk_en   = 1'b0;
        pulse_in = 1'b1;
        tick(4);
        check("rst_mid_out_before", outputs, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_async", outputs, 0);
        pulse_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_mid_idx", channel_idx, 0);
        check("rst_mid_synced", synced, 0);
        check("rst_mid_fault", dwell_fault, 0);
        hi_cnt   = 0;
        pulse_in = 1'b1;
        tick(6);
        pulse_in = 1'b0;
        tick(4);
        check("rst_mid_unsynced_hi", hi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
